// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath sequencer (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             zf;
    logic             of;
    logic             cf;
    logic             sf;

    modport master (output start, alu_op, a, b, input busy, done, f, zf, of, cf, sf);
    modport slave  (input start, alu_op, a, b, output busy, done, f, zf, of, cf, sf);
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; operands latched on accept.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 1011.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             zf_q, zf_d, of_q, of_d, cf_q, cf_d, sf_q, sf_d;
    logic             done_q, done_d;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0] res_f;
    logic             res_of, res_cf;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   sh;

    // Result is formed from the latched operands only; diff[WIDTH] is the unsigned borrow.
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        sh     = a_q[SHW-1:0];
        res_f  = '0;
        res_of = 1'b0;
        res_cf = 1'b0;
        case (op_q)
            4'b0000: res_f = a_q & b_q;
            4'b0001: res_f = a_q | b_q;
            4'b0010: res_f = a_q ^ b_q;
            4'b0011: res_f = ~(a_q ^ b_q);
            4'b0100: begin
                res_f  = sum[WIDTH-1:0];
                res_cf = sum[WIDTH];
                res_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'b0101: begin
                res_f  = diff[WIDTH-1:0];
                res_cf = diff[WIDTH];
                res_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'b0110: res_f = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            4'b0111: res_f = b_q << sh;
            4'b1000: res_f = {{(WIDTH-1){1'b0}}, a_q < b_q};
            4'b1001: res_f = b_q >> sh;
            4'b1010: res_f = $signed(b_q) >>> sh;
`ifdef ALU_MUL_EN
            4'b1011: begin
                res_f  = acc_q[WIDTH-1:0];
                res_of = |acc_q[2*WIDTH-1:WIDTH];
            end
`endif
            default: res_f = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        zf_d    = zf_q;
        of_d    = of_q;
        cf_d    = cf_q;
        sf_d    = sf_q;
        done_d  = 1'b0;
`ifdef ALU_MUL_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.alu_op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_EXEC;
`ifdef ALU_MUL_EN
                    if (bus.alu_op == 4'b1011) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
            S_EXEC: begin
                f_d     = res_f;
                zf_d    = (res_f == '0);
                sf_d    = res_f[WIDTH-1];
                of_d    = res_of;
                cf_d    = res_cf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`ifdef ALU_MUL_EN
            // One multiplier bit of a per cycle; EXEC then publishes the accumulator.
            S_MUL: begin
                if (a_q[cnt_q])
                    acc_d = acc_q + ({{WIDTH{1'b0}}, b_q} << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1))
                    state_d = S_EXEC;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
            sf_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            zf_q    <= zf_d;
            of_q    <= of_d;
            cf_q    <= cf_d;
            sf_q    <= sf_d;
            done_q  <= done_d;
`ifdef ALU_MUL_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.f    = f_q;
    assign bus.zf   = zf_q;
    assign bus.of   = of_q;
    assign bus.cf   = cf_q;
    assign bus.sf   = sf_q;
endmodule
